// File: rtl/nco_pkg.sv
// nco_pkg: shared widths, quadrant type, sample type and quarter-wave LUT builder for the NCO
package nco_pkg;
  localparam int DEF_PHASE_W = 32;
  localparam int DEF_LUT_AW = 10;
  localparam int DEF_OUT_W = 16;
  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_t;
  typedef logic signed [DEF_OUT_W-1:0] sample_t;
  // Half-step offset keeps every entry strictly positive so negation cannot overflow
  function automatic int lut_entry(int k, int aw, int ow);
    real amp, x;
    amp = real'((2 ** (ow - 1)) - 1);
    x = amp * $sin(6.283185307179586 * (real'(k) + 0.5) / real'(4 * (2 ** aw)));
    return $rtoi(x + 0.5);
  endfunction
endpackage

// File: rtl/nco_reference_gen_if.sv
// nco_reference_gen_if: control, tuning handshake and quadrature sample stream of the NCO
interface nco_reference_gen_if import nco_pkg::*; #(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int OUT_W = DEF_OUT_W
);
  logic enable, freq_valid, freq_ready, sync, out_valid;
  logic [PHASE_W-1:0] freq_word, phase_offset;
  logic signed [OUT_W-1:0] cos, sin;
  modport master(
    output enable, freq_word, freq_valid, phase_offset, sync,
    input freq_ready, cos, sin, out_valid
  );
  modport slave(
    input enable, freq_word, freq_valid, phase_offset, sync,
    output freq_ready, cos, sin, out_valid
  );
endinterface

// File: rtl/nco_quarter_lut.sv
// nco_quarter_lut: dual-read-port synchronous quarter-wave sine ROM
module nco_quarter_lut import nco_pkg::*; #(
  parameter int AW = DEF_LUT_AW,
  parameter int DW = DEF_OUT_W - 1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_a,
  input  logic [AW-1:0] addr_b,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b
);
  logic [DW-1:0] rom [2**AW];
  for (genvar i = 0; i < 2**AW; i++) begin : g
    localparam logic [DW-1:0] V = DW'(lut_entry(i, AW, DW + 1));
    assign rom[i] = V;
  end
  always_ff @(posedge clk) begin
    data_a <= rom[addr_a];
    data_b <= rom[addr_b];
  end
endmodule

// File: rtl/nco_reference_gen.sv
// nco_reference_gen: quadrature NCO emitting one cos/sin sample every DECIM clocks
module nco_reference_gen import nco_pkg::*; #(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int LUT_AW = DEF_LUT_AW,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DECIM = 2
) (
  input logic clk,
  input logic rst,
  nco_reference_gen_if.slave bus
);
  localparam int CW = DECIM > 1 ? $clog2(DECIM) : 1;
  logic [CW-1:0] cnt;
  logic [PHASE_W-1:0] acc, freq_active, pending_word;
  logic [LUT_AW+1:0] p_top;
  logic [LUT_AW-1:0] a, a_sin, a_cos;
  logic [OUT_W-2:0] l_sin, l_cos;
  logic pending, st, v1, v2, out_valid;
  logic signed [OUT_W-1:0] cos_q, sin_q;
  quad_t q1, q2;
  // Only quadrant + LUT address bits of the offset phase matter; the rest is truncated
  always_comb begin
    st = bus.enable && cnt == '0 && !bus.sync;
    p_top = (LUT_AW+2)'((acc + bus.phase_offset) >> (PHASE_W - 2 - LUT_AW));
    a = p_top[LUT_AW-1:0];
  end
  assign bus.freq_ready = !pending;
  assign bus.cos = cos_q;
  assign bus.sin = sin_q;
  assign bus.out_valid = out_valid;
  always_ff @(posedge clk) begin
    if (rst || bus.sync) begin
      cnt <= '0;
      acc <= '0;
    end else if (bus.enable) begin
      cnt <= cnt == CW'(DECIM - 1) ? '0 : cnt + 1'b1;
      if (st) acc <= acc + (pending ? pending_word : freq_active);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      pending_word <= '0;
      freq_active <= '0;
    end else if (st && pending) begin
      freq_active <= pending_word;
      pending <= 1'b0;
    end else if (bus.freq_valid && !pending) begin
      pending <= 1'b1;
      pending_word <= bus.freq_word;
    end
  end
  // Odd quadrants read the mirrored address for sine and the direct one for cosine
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      q1 <= Q0;
      q2 <= Q0;
      a_sin <= '0;
      a_cos <= '0;
      cos_q <= '0;
      sin_q <= '0;
    end else begin
      v1 <= st;
      v2 <= v1 && !bus.sync;
      out_valid <= v2 && !bus.sync;
      q2 <= q1;
      if (st) begin
        q1 <= quad_t'(p_top[LUT_AW+1 -: 2]);
        a_sin <= p_top[LUT_AW] ? ~a : a;
        a_cos <= p_top[LUT_AW] ? a : ~a;
      end
      if (v2 && !bus.sync) begin
        sin_q <= q2 inside {Q2, Q3} ? OUT_W'(-{1'b0, l_sin}) : {1'b0, l_sin};
        cos_q <= q2 inside {Q1, Q2} ? OUT_W'(-{1'b0, l_cos}) : {1'b0, l_cos};
      end
    end
  end
  nco_quarter_lut #(.AW(LUT_AW), .DW(OUT_W - 1)) lut (
    .clk(clk),
    .addr_a(a_sin),
    .addr_b(a_cos),
    .data_a(l_sin),
    .data_b(l_cos)
  );
endmodule

// File: tb/tb_nco_reference_gen.sv
// tb_nco_reference_gen: directed and random checks of the NCO against a full-wave trig model
module tb_nco_reference_gen;
  import nco_pkg::*;
  localparam int DECIM = 2;
  typedef struct {
    int due;
    logic [31:0] ph;
  } item_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  nco_reference_gen_if bus();
  nco_reference_gen #(.DECIM(DECIM)) dut (.clk(clk), .rst(rst), .bus(bus));
  item_t sched[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [31:0] m_acc, m_active, m_pword;
  bit m_pend;
  int m_cnt;
  sample_t m_sin, m_cos;

  function automatic sample_t rnd(real v);
    return v < 0.0 ? -sample_t'($rtoi(-v + 0.5)) : sample_t'($rtoi(v + 0.5));
  endfunction

  // Expected sample straight from the full-wave sin/cos at the LUT bin centre
  task automatic ref_sample(input logic [31:0] ph, output sample_t s, output sample_t c);
    real x;
    x = 6.283185307179586 * (real'(ph[31:20]) + 0.5) / 4096.0;
    s = rnd(32767.0 * $sin(x));
    c = rnd(32767.0 * $cos(x));
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit st, acc_ok;
    if (rst) begin
      m_acc = 0; m_active = 0; m_pword = 0; m_pend = 0; m_cnt = 0;
      m_sin = 0; m_cos = 0;
      sched.delete();
    end else begin
      acc_ok = bus.freq_valid && !m_pend;
      if (bus.sync) begin
        m_acc = 0; m_cnt = 0;
        sched.delete();
      end else begin
        st = bus.enable && m_cnt == 0;
        if (st) begin
          sched.push_back('{cyc + 3, m_acc + bus.phase_offset});
          if (m_pend) begin
            m_active = m_pword;
            m_pend = 0;
          end
          m_acc = m_acc + m_active;
        end
        if (bus.enable) m_cnt = (m_cnt + 1) % DECIM;
      end
      if (acc_ok) begin
        m_pend = 1;
        m_pword = bus.freq_word;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    if (sched.size() > 0 && sched[0].due == cyc) begin
      ref_sample(sched[0].ph, m_sin, m_cos);
      void'(sched.pop_front());
      chk("out_valid", bus.out_valid, 1);
    end else chk("out_valid", bus.out_valid, 0);
    chk("sin", bus.sin, m_sin);
    chk("cos", bus.cos, m_cos);
    chk("freq_ready", bus.freq_ready, m_pend ? 0 : 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input logic [31:0] w);
    bit ok;
    int n = 0;
    bus.freq_valid = 1'b1;
    bus.freq_word = w;
    do begin
      ok = bus.freq_ready;
      step();
      n++;
    end while (!ok && n < 200);
    bus.freq_valid = 1'b0;
    if (!ok) chk("load_timeout", 0, 1);
  endtask

  task automatic wait_pulse(input int s, input int c);
    int n = 0;
    do begin
      step();
      n++;
    end while (bus.out_valid !== 1'b1 && n < 20);
    chk("pulse_seen", bus.out_valid, 1);
    chk("dir_sin", bus.sin, s);
    chk("dir_cos", bus.cos, c);
  endtask

  initial begin
    bus.enable = 1'b0; bus.freq_valid = 1'b0; bus.freq_word = '0;
    bus.phase_offset = '0; bus.sync = 1'b0;
    run(3);
    rst = 1'b0;
    // 90-degree sweep
    load(32'h4000_0000);
    bus.enable = 1'b1;
    wait_pulse(25, 32767);
    wait_pulse(32767, -25);
    wait_pulse(-25, -32767);
    wait_pulse(-32767, 25);
    run(10);
    // static half-turn offset with zero increment
    bus.enable = 1'b0;
    bus.sync = 1'b1; step(); bus.sync = 1'b0;
    load(32'h0);
    bus.phase_offset = 32'h8000_0000;
    bus.enable = 1'b1;
    wait_pulse(-25, -32767);
    wait_pulse(-25, -32767);
    bus.phase_offset = '0;
    // back-to-back tuning words while running
    load(32'h4000_0000);
    chk("bp_ready", bus.freq_ready, 0);
    load(32'h2000_0000);
    run(16);
    // accumulator wrap
    bus.enable = 1'b0;
    bus.sync = 1'b1; step(); bus.sync = 1'b0;
    load(32'hFFFF_FFFF);
    bus.enable = 1'b1;
    wait_pulse(25, 32767);
    wait_pulse(-25, 32767);
    // sync mid-stream drops in-flight samples, keeps the active word
    load(32'h4000_0000);
    run(7);
    bus.sync = 1'b1; step(); bus.sync = 1'b0;
    wait_pulse(25, 32767);
    wait_pulse(32767, -25);
    // reset with an update pending and enable low
    bus.enable = 1'b0;
    run(4);
    load(32'h2000_0000);
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_ready", bus.freq_ready, 1);
    chk("rst_sin", bus.sin, 0);
    bus.enable = 1'b1;
    wait_pulse(25, 32767);
    wait_pulse(25, 32767);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom % 150) == 0;
      bus.sync = ($urandom % 40) == 0;
      bus.enable = ($urandom % 8) != 0;
      bus.freq_valid = ($urandom % 4) == 0;
      bus.freq_word = $urandom;
      if (($urandom % 20) == 0) bus.phase_offset = $urandom;
      step();
    end
    rst = 1'b0; bus.sync = 1'b0; bus.freq_valid = 1'b0;
    run(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
